// File: rtl/uas.sv
// -----------------------------------------------------------------------------
// uas -- 4-bit two's-complement adder/subtractor, scalar bit-level ports.
//
// Purpose:
//   Computes A+B (M=0) or A-B (M=1) through a 4-stage ripple-carry chain.
//   Each stage adds Ai, (Bi ^ M) and the incoming carry. The chain is seeded
//   with C0 = M, so subtraction is A + ~B + 1.
//
// Parameters:
//   OUT_REG  1 = S/C4/V (and Z) registered on clk, 1-cycle latency (default)
//            0 = outputs are purely combinational; clk and rst_n are ignored
//
// Optional feature (compile-time macro):
//   UAS_ZERO_FLAG_EN  when defined, adds output Z (1 when S3..S0 == 0000).
//                     Z is timed exactly like S and resets to 1.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (registered build only)
//   A3..A0       operand A, A3 = sign
//   B3..B0       operand B, B3 = sign
//   M            0 = add, 1 = subtract
//   C4           carry out of bit 3 (subtract: 1 = no borrow)
//   S3..S0       result bits
//   V            signed overflow (carry into bit 3 XOR carry out of bit 3)
//   Z            zero flag (only with UAS_ZERO_FLAG_EN)
// -----------------------------------------------------------------------------
module uas #(
    parameter int OUT_REG = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic A0,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic B0,
    input  logic B1,
    input  logic B2,
    input  logic B3,
    input  logic M,
    output logic C4,
    output logic S0,
    output logic S1,
    output logic S2,
    output logic S3,
    output logic V
`ifdef UAS_ZERO_FLAG_EN
    ,
    output logic Z
`endif
);

    logic [3:0] a_vec;
    logic [3:0] b_vec;
    logic [4:0] carry;      // carry[i] is the carry into stage i
    logic [3:0] sum_next;
    logic       c4_next;
    logic       v_next;

    assign a_vec    = {A3, A2, A1, A0};
    assign b_vec    = {B3, B2, B1, B0};
    assign carry[0] = M;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_stage
            logic b_x;
            logic p;
            assign b_x          = b_vec[gi] ^ M;
            assign p            = a_vec[gi] ^ b_x;
            assign sum_next[gi] = p ^ carry[gi];
            assign carry[gi+1]  = (a_vec[gi] & b_x) | (p & carry[gi]);
        end
    endgenerate

    assign c4_next = carry[4];
    assign v_next  = carry[3] ^ carry[4];

`ifdef UAS_ZERO_FLAG_EN
    logic z_next;
    assign z_next = ~|sum_next;
`endif

    generate
        if (OUT_REG != 0) begin : g_reg
            logic [3:0] sum_reg;
            logic       c4_reg;
            logic       v_reg;

            // Reset clears the result register, which discards any pending
            // result and holds outputs at zero while rst_n is low.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_reg <= 4'b0000;
                    c4_reg  <= 1'b0;
                    v_reg   <= 1'b0;
                end else begin
                    sum_reg <= sum_next;
                    c4_reg  <= c4_next;
                    v_reg   <= v_next;
                end
            end

            assign {S3, S2, S1, S0} = sum_reg;
            assign C4               = c4_reg;
            assign V                = v_reg;

`ifdef UAS_ZERO_FLAG_EN
            logic z_reg;
            // Reset value is 1 so Z agrees with the cleared sum.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    z_reg <= 1'b1;
                end else begin
                    z_reg <= z_next;
                end
            end
            assign Z = z_reg;
`endif
        end else begin : g_comb
            assign {S3, S2, S1, S0} = sum_next;
            assign C4               = c4_next;
            assign V                = v_next;
`ifdef UAS_ZERO_FLAG_EN
            assign Z = z_next;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_uas.sv
// -----------------------------------------------------------------------------
// tb_uas -- self-checking bench for uas (default OUT_REG=1).
// Inputs are driven just after the falling edge; outputs are sampled on the
// falling edge, half a cycle after the capturing rising edge.
// -----------------------------------------------------------------------------
module tb_uas;

    logic clk;
    logic rst_n;
    logic A0, A1, A2, A3;
    logic B0, B1, B2, B3;
    logic M;
    logic C4, S0, S1, S2, S3, V;
`ifdef UAS_ZERO_FLAG_EN
    logic Z;
`endif

    int checks;
    int errors;

    uas #(.OUT_REG(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A0    (A0),
        .A1    (A1),
        .A2    (A2),
        .A3    (A3),
        .B0    (B0),
        .B1    (B1),
        .B2    (B2),
        .B3    (B3),
        .M     (M),
        .C4    (C4),
        .S0    (S0),
        .S1    (S1),
        .S2    (S2),
        .S3    (S3),
        .V     (V)
`ifdef UAS_ZERO_FLAG_EN
        ,
        .Z     (Z)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed result packed as {C4, V, S3, S2, S1, S0}.
    function automatic logic [5:0] obs();
        return {C4, V, S3, S2, S1, S0};
    endfunction

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic m);
        {A3, A2, A1, A0} = a;
        {B3, B2, B1, B0} = b;
        M = m;
    endtask

    task automatic test_reset();
        logic [5:0] o;
        rst_n = 1'b0;
        drive(4'd9, 4'd10, 1'b0);
        repeat (2) @(negedge clk);
        o = obs();
        checks++;
        if (o !== 6'b000000) begin
            errors++;
            $display("FAIL reset_state got %b want %b", o, 6'b000000);
        end
`ifdef UAS_ZERO_FLAG_EN
        checks++;
        if (Z !== 1'b1) begin
            errors++;
            $display("FAIL reset_z got %b want 1", Z);
        end
`endif
        rst_n = 1'b1;
        $display("reset: outputs=%b", o);
    endtask

    task automatic test_vectors();
        logic [3:0] va [6];
        logic [3:0] vb [6];
        logic       vm [6];
        logic [5:0] ve [6];
        logic [5:0] o;
        va[0] = 4'b1001; vb[0] = 4'b1010; vm[0] = 1'b0; ve[0] = 6'b110011;
        va[1] = 4'b1001; vb[1] = 4'b1010; vm[1] = 1'b1; ve[1] = 6'b001111;
        va[2] = 4'b0111; vb[2] = 4'b0001; vm[2] = 1'b0; ve[2] = 6'b011000;
        va[3] = 4'b1000; vb[3] = 4'b0001; vm[3] = 1'b1; ve[3] = 6'b110111;
        va[4] = 4'b0000; vb[4] = 4'b0000; vm[4] = 1'b1; ve[4] = 6'b100000;
        va[5] = 4'b0011; vb[5] = 4'b0101; vm[5] = 1'b1; ve[5] = 6'b001110;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(va[i], vb[i], vm[i]);
            @(negedge clk);
            o = obs();
            checks++;
            if (o !== ve[i]) begin
                errors++;
                $display("FAIL vector%0d got %b want %b", i, o, ve[i]);
            end
`ifdef UAS_ZERO_FLAG_EN
            checks++;
            if (Z !== (ve[i][3:0] == 4'b0000)) begin
                errors++;
                $display("FAIL vector%0d_z got %b want %b", i, Z, ve[i][3:0] == 4'b0000);
            end
`endif
            $display("vector%0d: A=%b B=%b M=%b -> C4V_S=%b", i, va[i], vb[i], vm[i], o);
        end
    endtask

    // Inputs changed after the capturing edge must not reach the outputs.
    task automatic test_hold_between_edges();
        logic [5:0] o;
        @(negedge clk);
        drive(4'd2, 4'd3, 1'b0);            // 2+3 = 5
        @(posedge clk);
        #2;
        drive(4'd15, 4'd15, 1'b0);          // would give 1110, C4=1
        @(negedge clk);
        o = obs();
        checks++;
        if (o !== 6'b000101) begin
            errors++;
            $display("FAIL hold_between_edges got %b want %b", o, 6'b000101);
        end
        $display("hold: outputs=%b", o);
    endtask

    task automatic test_async_reset();
        logic [5:0] o;
        @(negedge clk);
        drive(4'b1111, 4'b0001, 1'b0);
        @(negedge clk);
        o = obs();
        checks++;
        if (o !== 6'b100000) begin
            errors++;
            $display("FAIL pre_reset_result got %b want %b", o, 6'b100000);
        end
        #2;
        rst_n = 1'b0;                       // between edges, no clk involved
        #1;
        o = obs();
        checks++;
        if (o !== 6'b000000) begin
            errors++;
            $display("FAIL async_clear got %b want %b", o, 6'b000000);
        end
        @(negedge clk);                     // a rising edge passed with rst_n low
        o = obs();
        checks++;
        if (o !== 6'b000000) begin
            errors++;
            $display("FAIL reset_hold got %b want %b", o, 6'b000000);
        end
        #2;
        rst_n = 1'b1;
        #1;
        o = obs();
        checks++;
        if (o !== 6'b000000) begin
            errors++;
            $display("FAIL release_no_edge got %b want %b", o, 6'b000000);
        end
        @(negedge clk);
        o = obs();
        checks++;
        if (o !== 6'b100000) begin
            errors++;
            $display("FAIL result_after_release got %b want %b", o, 6'b100000);
        end
        $display("async_reset: result after release=%b", o);
    endtask

    // Back-to-back exhaustive sweep: a new operand set every cycle, each
    // result checked one cycle later against an arithmetic model.
    task automatic test_sweep();
        logic [5:0] exp_prev;
        logic       have_prev;
        logic [5:0] o;
        int         sweep_err;
        have_prev = 1'b0;
        exp_prev  = '0;
        sweep_err = 0;
        for (int k = 0; k <= 512; k++) begin
            @(negedge clk);
            if (have_prev) begin
                o = obs();
                checks++;
                if (o !== exp_prev) begin
                    errors++;
                    sweep_err++;
                    $display("FAIL sweep_idx%0d got %b want %b", k - 1, o, exp_prev);
                end
`ifdef UAS_ZERO_FLAG_EN
                checks++;
                if (Z !== (exp_prev[3:0] == 4'b0000)) begin
                    errors++;
                    sweep_err++;
                    $display("FAIL sweep_z_idx%0d got %b want %b", k - 1, Z, exp_prev[3:0] == 4'b0000);
                end
`endif
            end
            if (k < 512) begin
                logic [3:0] a;
                logic [3:0] b;
                logic       m;
                logic [4:0] sum5;
                int         sa, sb, sr;
                a = k[3:0];
                b = k[7:4];
                m = k[8];
                if (m) sum5 = {1'b0, a} + {1'b0, ~b} + 5'd1;
                else   sum5 = {1'b0, a} + {1'b0, b};
                sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
                sb = (b >= 4'd8) ? int'(b) - 16 : int'(b);
                sr = m ? sa - sb : sa + sb;
                exp_prev  = {sum5[4], (sr > 7 || sr < -8), sum5[3:0]};
                have_prev = 1'b1;
                drive(a, b, m);
            end
        end
        $display("sweep: 512 results, %0d mismatching", sweep_err);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(4'd0, 4'd0, 1'b0);
        test_reset();
        test_vectors();
        test_hold_between_edges();
        test_async_reset();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
